pe_act_broadcast: RTL and testbench

//  Transmit side of the PE activation queue protocol. On pe_start_broadcast it scans this
//  PE's slice of the current layer's input activations from the activation register file and

---
 rtl/pe_act_broadcast_pkg.sv | 27 ++
 rtl/pe_bcast_fifo2.sv | 56 +++++
 rtl/pe_act_broadcast.sv | 144 ++++++++++++++
 tb/tb_pe_act_broadcast.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_act_broadcast_pkg.sv
// ============================================================================
// Module : pe_act_broadcast_pkg
// Brief  : Shared types for the PE activation broadcast transmit side.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_act_broadcast_pkg;

    localparam int c_pe_idx_w = 6;

    typedef enum logic {
        ACT_DIR_BANK0 = 1'b0,
        ACT_DIR_BANK1 = 1'b1
    } act_dir_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_TERM  = 3'd3,
        ST_FLUSH = 3'd4
    } bcast_state_t;

endpackage

`default_nettype wire

// File: rtl/pe_bcast_fifo2.sv
// ============================================================================
// Module : pe_bcast_fifo2
// Brief  : Two-entry packet FIFO with occupancy count and same-cycle push/pop.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_bcast_fifo2 #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [1:0]       o_occ,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ   = r_occ;
    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/pe_act_broadcast.sv
// ============================================================================
// Module : pe_act_broadcast
// Brief  : Scans this PE's activation slice, drops zeros, and broadcasts
//          {global_idx, value} packets followed by an all-zero terminator.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_act_broadcast
    import pe_act_broadcast_pkg::*;
#(
    parameter int NUM_PE   = 64,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int ACT_NO_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [c_pe_idx_w-1:0]    pe_idx,
    input  logic                     pe_start_broadcast,
    input  logic                     act_regfile_dir,
    input  logic [ACT_NO_W-1:0]      in_act_no,
    output logic                     act_rd_en,
    output logic                     act_rd_bank,
    output logic [ACT_NO_W-1:0]      act_rd_addr,
    input  logic [DATA_W-1:0]        act_rd_data,
    output logic                     pkt_valid,
    input  logic                     pkt_ready,
    output logic [ADDR_W+DATA_W-1:0] pkt_data,
    output logic                     bcast_busy,
    output logic                     bcast_done
);

    localparam int PKT_W    = ADDR_W + DATA_W;
    localparam int PE_SHIFT = $clog2(NUM_PE);

    bcast_state_t          r_state;
    act_dir_t              r_bank;
    logic [ACT_NO_W-1:0]   r_act_no;
    logic [ACT_NO_W-1:0]   r_addr;
    logic [ACT_NO_W-1:0]   r_inflight_addr;
    logic                  r_inflight;
    logic                  r_done;

    logic [1:0]            w_occ;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_ret_push;
    logic                  w_term_push;
    logic                  w_push;
    logic [ADDR_W-1:0]     w_gidx;
    logic [PKT_W-1:0]      w_push_data;

    assign w_pop = pkt_valid & pkt_ready;

    // A read is only issued when its return is guaranteed a FIFO slot.
    assign w_issue = (r_state == ST_SCAN) &&
                     (({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

    assign w_ret_push  = r_inflight && (act_rd_data != '0);
    assign w_term_push = (r_state == ST_TERM) &&
                         ({1'b0, w_occ} < (3'd2 + {2'b00, w_pop}));
    assign w_push      = w_ret_push | w_term_push;

    // NUM_PE is a power of two, so addr*NUM_PE + pe_idx reduces to shift/OR.
    assign w_gidx      = (ADDR_W'(r_inflight_addr) << PE_SHIFT) | ADDR_W'(pe_idx);
    assign w_push_data = w_term_push ? '0 : {w_gidx, act_rd_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_bank          <= ACT_DIR_BANK0;
            r_act_no        <= '0;
            r_addr          <= '0;
            r_inflight_addr <= '0;
            r_inflight      <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_addr <= r_addr;
                r_addr          <= r_addr + ACT_NO_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (pe_start_broadcast) begin
                        r_bank   <= act_dir_t'(act_regfile_dir);
                        r_act_no <= in_act_no;
                        r_addr   <= '0;
                        r_state  <= (in_act_no == '0) ? ST_TERM : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_issue && (r_addr == (r_act_no - ACT_NO_W'(1)))) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!r_inflight) begin
                        r_state <= ST_TERM;
                    end
                end
                ST_TERM: begin
                    if (w_term_push) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // The terminator is always the last entry left in the FIFO.
                    if (w_pop && (w_occ == 2'd1)) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    pe_bcast_fifo2 #(
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_valid     (pkt_valid),
        .o_data      (pkt_data)
    );

    assign act_rd_en   = w_issue;
    assign act_rd_bank = r_bank;
    assign act_rd_addr = r_addr;
    assign bcast_busy  = (r_state != ST_IDLE);
    assign bcast_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pe_act_broadcast.sv
// ============================================================================
// Module : tb_pe_act_broadcast
// Brief  : Directed self-checking bench for pe_act_broadcast.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_act_broadcast;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 16;
    localparam int ACT_NO_W = 6;
    localparam int PKT_W    = ADDR_W + DATA_W;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [5:0]          pe_idx = '0;
    logic                pe_start_broadcast = 1'b0;
    logic                act_regfile_dir = 1'b0;
    logic [ACT_NO_W-1:0] in_act_no = '0;
    logic                act_rd_en;
    logic                act_rd_bank;
    logic [ACT_NO_W-1:0] act_rd_addr;
    logic [DATA_W-1:0]   act_rd_data = '0;
    logic                pkt_valid;
    logic                pkt_ready = 1'b0;
    logic [PKT_W-1:0]    pkt_data;
    logic                bcast_busy;
    logic                bcast_done;

    int checks   = 0;
    int failures = 0;

    pe_act_broadcast u_dut (
        .clk                (clk),
        .rst                (rst),
        .pe_idx             (pe_idx),
        .pe_start_broadcast (pe_start_broadcast),
        .act_regfile_dir    (act_regfile_dir),
        .in_act_no          (in_act_no),
        .act_rd_en          (act_rd_en),
        .act_rd_bank        (act_rd_bank),
        .act_rd_addr        (act_rd_addr),
        .act_rd_data        (act_rd_data),
        .pkt_valid          (pkt_valid),
        .pkt_ready          (pkt_ready),
        .pkt_data           (pkt_data),
        .bcast_busy         (bcast_busy),
        .bcast_done         (bcast_done)
    );

    always #5 clk = ~clk;

    // Activation regfile model: data valid the cycle after the read strobe.
    logic [DATA_W-1:0] mem [2][64];
    always @(posedge clk) begin
        if (act_rd_en) act_rd_data <= mem[act_rd_bank][act_rd_addr];
    end

    logic [PKT_W-1:0] pq[$];
    int done_cnt = 0;
    int rd_cnt   = 0;
    always @(posedge clk) begin
        if (pkt_valid && pkt_ready) pq.push_back(pkt_data);
        if (bcast_done) done_cnt <= done_cnt + 1;
        if (act_rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic do_start(input logic dir, input logic [ACT_NO_W-1:0] no);
        act_regfile_dir    = dir;
        in_act_no          = no;
        pe_start_broadcast = 1'b1;
        @(negedge clk);
        pe_start_broadcast = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL done_timeout got=no_done after %0d cycles exp=done", budget);
        end
    endtask

    task automatic test_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 64; a++) mem[b][a] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL reset_pkt_valid got=%0b exp=0", pkt_valid); end
        checks++; if (pkt_data !== '0) begin failures++; $display("FAIL reset_pkt_data got=%h exp=0", pkt_data); end
        checks++; if (bcast_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bcast_busy); end
        checks++; if (bcast_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bcast_done); end
        checks++; if (act_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%0b exp=0", act_rd_en); end
        checks++; if (act_rd_addr !== '0) begin failures++; $display("FAIL reset_rd_addr got=%0d exp=0", act_rd_addr); end
        checks++; if (act_rd_bank !== 1'b0) begin failures++; $display("FAIL reset_rd_bank got=%0b exp=0", act_rd_bank); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [PKT_W-1:0] exp_p [3];
        int p0 = pq.size();
        int d0 = done_cnt;
        int r0 = rd_cnt;
        exp_p[0] = {10'd3, 16'd5};
        exp_p[1] = {10'd195, 16'd7};
        exp_p[2] = '0;
        mem[0][0] = 16'd5; mem[0][1] = 16'd0; mem[0][2] = 16'd0; mem[0][3] = 16'd7;
        pe_idx = 6'd3;
        pkt_ready = 1'b1;
        do_start(1'b0, 6'd4);
        checks++; if (act_rd_en !== 1'b1 || act_rd_addr !== 6'd0) begin failures++; $display("FAIL basic_first_read got=en%0b/a%0d exp=en1/a0", act_rd_en, act_rd_addr); end
        checks++; if (bcast_busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", bcast_busy); end
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_t1 got=%0b exp=0", pkt_valid); end
        @(negedge clk);
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_t2 got=%0b exp=0", pkt_valid); end
        @(negedge clk);
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== exp_p[0]) begin failures++; $display("FAIL basic_first_pkt got=v%0b/%h exp=v1/%h", pkt_valid, pkt_data, exp_p[0]); end
        wait_done(d0, 40);
        repeat (3) @(negedge clk);
        checks++; if (pq.size() - p0 !== 3) begin failures++; $display("FAIL basic_pkt_count got=%0d exp=3", pq.size() - p0); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (pq[p0+i] !== exp_p[i]) begin failures++; $display("FAIL basic_pkt%0d got=%h exp=%h", i, pq[p0+i], exp_p[i]); end
        end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (rd_cnt - r0 !== 4) begin failures++; $display("FAIL basic_reads got=%0d exp=4", rd_cnt - r0); end
        checks++; if (bcast_busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%0b exp=0", bcast_busy); end
    endtask

    task automatic test_zero_count();
        int p0 = pq.size();
        int d0 = done_cnt;
        int r0 = rd_cnt;
        pkt_ready = 1'b1;
        do_start(1'b0, 6'd0);
        checks++; if (pkt_valid !== 1'b0 || act_rd_en !== 1'b0 || bcast_busy !== 1'b1) begin failures++; $display("FAIL zero_t1 got=v%0b/en%0b/b%0b exp=v0/en0/b1", pkt_valid, act_rd_en, bcast_busy); end
        @(negedge clk);
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== '0) begin failures++; $display("FAIL zero_term_t2 got=v%0b/%h exp=v1/0", pkt_valid, pkt_data); end
        checks++; if (bcast_done !== 1'b0) begin failures++; $display("FAIL zero_done_early got=%0b exp=0", bcast_done); end
        @(negedge clk);
        checks++; if (bcast_done !== 1'b1) begin failures++; $display("FAIL zero_done_pulse got=%0b exp=1", bcast_done); end
        repeat (2) @(negedge clk);
        checks++; if (rd_cnt - r0 !== 0) begin failures++; $display("FAIL zero_reads got=%0d exp=0", rd_cnt - r0); end
        checks++; if (pq.size() - p0 !== 1 || pq[p0] !== '0) begin failures++; $display("FAIL zero_pkts got=n%0d/%h exp=n1/0", pq.size() - p0, pq[p0]); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_backpressure();
        logic [PKT_W-1:0] exp_p [5];
        bit stable = 1'b1;
        int p0 = pq.size();
        int d0 = done_cnt;
        int r0 = rd_cnt;
        exp_p[0] = {10'd3, 16'd1};
        exp_p[1] = {10'd67, 16'd2};
        exp_p[2] = {10'd131, 16'd3};
        exp_p[3] = {10'd195, 16'd4};
        exp_p[4] = '0;
        for (int a = 0; a < 4; a++) mem[1][a] = DATA_W'(a + 1);
        pe_idx = 6'd3;
        pkt_ready = 1'b0;
        do_start(1'b1, 6'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2 && pkt_data !== exp_p[0]) stable = 1'b0;
        end
        checks++; if (rd_cnt - r0 !== 2) begin failures++; $display("FAIL bp_reads got=%0d exp=2", rd_cnt - r0); end
        checks++; if (act_rd_en !== 1'b0) begin failures++; $display("FAIL bp_rd_en_low got=%0b exp=0", act_rd_en); end
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== exp_p[0]) begin failures++; $display("FAIL bp_head got=v%0b/%h exp=v1/%h", pkt_valid, pkt_data, exp_p[0]); end
        checks++; if (!stable) begin failures++; $display("FAIL bp_stable got=changed exp=stable"); end
        checks++; if (act_rd_bank !== 1'b1) begin failures++; $display("FAIL bp_bank got=%0b exp=1", act_rd_bank); end
        pkt_ready = 1'b1;
        wait_done(d0, 40);
        repeat (2) @(negedge clk);
        checks++; if (pq.size() - p0 !== 5) begin failures++; $display("FAIL bp_pkt_count got=%0d exp=5", pq.size() - p0); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (pq[p0+i] !== exp_p[i]) begin failures++; $display("FAIL bp_pkt%0d got=%h exp=%h", i, pq[p0+i], exp_p[i]); end
        end
    endtask

    task automatic test_all_zero();
        int p0 = pq.size();
        int d0 = done_cnt;
        int r0 = rd_cnt;
        for (int a = 0; a < 6; a++) mem[0][a] = '0;
        pe_idx = 6'd5;
        pkt_ready = 1'b1;
        do_start(1'b0, 6'd6);
        wait_done(d0, 40);
        repeat (2) @(negedge clk);
        checks++; if (rd_cnt - r0 !== 6) begin failures++; $display("FAIL allzero_reads got=%0d exp=6", rd_cnt - r0); end
        checks++; if (pq.size() - p0 !== 1 || pq[p0] !== '0) begin failures++; $display("FAIL allzero_pkts got=n%0d/%h exp=n1/0", pq.size() - p0, pq[p0]); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL allzero_done got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_restart_ignored();
        logic [PKT_W-1:0] exp_p [5];
        int p0 = pq.size();
        int d0 = done_cnt;
        int r0 = rd_cnt;
        exp_p[0] = {10'd1, 16'd9};
        exp_p[1] = {10'd65, 16'd8};
        exp_p[2] = {10'd129, 16'd7};
        exp_p[3] = {10'd193, 16'd6};
        exp_p[4] = '0;
        mem[0][0] = 16'd9;  mem[0][1] = 16'd8;  mem[0][2] = 16'd7;  mem[0][3] = 16'd6;
        mem[1][0] = 16'd11; mem[1][1] = 16'd12; mem[1][2] = 16'd13; mem[1][3] = 16'd14;
        pe_idx = 6'd1;
        pkt_ready = 1'b0;
        do_start(1'b0, 6'd4);
        @(negedge clk);
        do_start(1'b1, 6'd2);
        checks++; if (act_rd_bank !== 1'b0) begin failures++; $display("FAIL restart_bank got=%0b exp=0", act_rd_bank); end
        pkt_ready = 1'b1;
        wait_done(d0, 40);
        repeat (5) @(negedge clk);
        checks++; if (pq.size() - p0 !== 5) begin failures++; $display("FAIL restart_pkt_count got=%0d exp=5", pq.size() - p0); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (pq[p0+i] !== exp_p[i]) begin failures++; $display("FAIL restart_pkt%0d got=%h exp=%h", i, pq[p0+i], exp_p[i]); end
        end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL restart_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (rd_cnt - r0 !== 4) begin failures++; $display("FAIL restart_reads got=%0d exp=4", rd_cnt - r0); end
    endtask

    task automatic test_reset_mid();
        int p0;
        int d0;
        int r0;
        for (int a = 0; a < 6; a++) mem[0][a] = DATA_W'(21 + a);
        pe_idx = 6'd2;
        pkt_ready = 1'b1;
        do_start(1'b0, 6'd6);
        repeat (2) @(negedge clk);
        checks++; if (pkt_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%0b exp=1", pkt_valid); end
        rst = 1'b1;
        #1;
        checks++; if (pkt_valid !== 1'b0 || bcast_busy !== 1'b0 || act_rd_en !== 1'b0) begin failures++; $display("FAIL rstmid_clear got=v%0b/b%0b/en%0b exp=0/0/0", pkt_valid, bcast_busy, act_rd_en); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        p0 = pq.size();
        d0 = done_cnt;
        r0 = rd_cnt;
        mem[0][0] = 16'd4;
        mem[0][1] = 16'd0;
        do_start(1'b0, 6'd2);
        checks++; if (act_rd_en !== 1'b1 || act_rd_addr !== 6'd0) begin failures++; $display("FAIL rstmid_rescan got=en%0b/a%0d exp=en1/a0", act_rd_en, act_rd_addr); end
        wait_done(d0, 40);
        repeat (2) @(negedge clk);
        checks++; if (pq.size() - p0 !== 2) begin failures++; $display("FAIL rstmid_pkt_count got=%0d exp=2", pq.size() - p0); end
        checks++; if (pq[p0] !== {10'd2, 16'd4}) begin failures++; $display("FAIL rstmid_pkt0 got=%h exp=%h", pq[p0], {10'd2, 16'd4}); end
        checks++; if (pq[p0+1] !== '0) begin failures++; $display("FAIL rstmid_term got=%h exp=0", pq[p0+1]); end
        checks++; if (rd_cnt - r0 !== 2) begin failures++; $display("FAIL rstmid_reads got=%0d exp=2", rd_cnt - r0); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_count();
        test_backpressure();
        test_all_zero();
        test_restart_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
